// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the SRAM responder state type.
package ahb_lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_ERR1,
      ST_ERR2
   } slv_state_e;

endpackage

// File: rtl/ahb_byte_lane_dec.sv
// Little-endian write lane mask from transfer size and low address bits.
module ahb_byte_lane_dec
   import ahb_lite_pkg::*;
(
   input  logic [2:0] hsize,
   input  logic [1:0] addr_lo,
   output logic [3:0] lane_mask
);

   always_comb begin
      lane_mask = 4'b0000;
      case (hsize)
         HSIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
         HSIZE_HALF: lane_mask = 4'b0011 << addr_lo;
         HSIZE_WORD: lane_mask = 4'b1111;
         default:    lane_mask = 4'b0000;
      endcase
   end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: word-wide memory, fixed wait states per beat,
// two-cycle ERROR response for out-of-range, misaligned or oversize accesses.
module ahb_lite_sram_slave
   import ahb_lite_pkg::*;
#(
   parameter int MEM_WORDS   = 1024,
   parameter int WAIT_STATES = 0
)
(
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

   logic [31:0] mem [MEM_WORDS];

   slv_state_e  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        dphase_q, dphase_d;
   logic [31:0] addr_q, addr_d;
   logic        write_q, write_d;
   logic [2:0]  size_q, size_d;
   logic [31:0] hrdata_q, hrdata_d;

   logic          accept;
   logic          legal;
   logic          complete;
   logic          rd_load;
   logic [3:0]    lane_mask;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;
   logic [31:0]   rd_word;
   logic          unused_ok;

   ahb_byte_lane_dec u_lane_dec (
      .hsize     (size_q),
      .addr_lo   (addr_q[1:0]),
      .lane_mask (lane_mask)
   );

   assign HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_ERR2) ||
                      ((state_q == ST_ACCESS) && (cnt_q == 4'd0));
   assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   assign HRDATA    = hrdata_q;

   // HREADYOUT is low in every state that cannot take a new address phase.
   assign accept   = HSEL && HREADY && HTRANS[1] && HREADYOUT;
   assign complete = ((state_q == ST_IDLE) && dphase_q) ||
                     ((state_q == ST_ACCESS) && (cnt_q == 4'd0));
   assign wr_idx   = addr_q[AW+1:2];
   assign rd_idx   = accept ? HADDR[AW+1:2] : addr_q[AW+1:2];
   assign rd_load  = (accept && legal && !HWRITE && (WAIT_STATES == 0)) ||
                     ((state_q == ST_ACCESS) && (cnt_q == 4'd1) && !write_q);

   always_comb begin
      legal = (HADDR < MEM_BYTES);
      if (HSIZE > HSIZE_WORD)
         legal = 1'b0;
      if ((HSIZE == HSIZE_HALF) && HADDR[0])
         legal = 1'b0;
      if ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00))
         legal = 1'b0;
   end

   // Forward bytes of a write completing this cycle into a read of the same word.
   always_comb begin
      rd_word = mem[rd_idx];
      if (complete && write_q && (wr_idx == rd_idx)) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_mask[i])
               rd_word[8*i +: 8] = HWDATA[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dphase_d = 1'b0;
      addr_d   = addr_q;
      write_d  = write_q;
      size_d   = size_q;
      hrdata_d = rd_load ? rd_word : hrdata_q;

      case (state_q)
         ST_ACCESS: begin
            if (cnt_q != 4'd0)
               cnt_d = cnt_q - 4'd1;
            else
               state_d = ST_IDLE;
         end
         ST_ERR1: state_d = ST_ERR2;
         ST_ERR2: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (accept) begin
         addr_d  = HADDR;
         write_d = HWRITE;
         size_d  = HSIZE;
         if (!legal) begin
            state_d = ST_ERR1;
         end else if (WAIT_STATES == 0) begin
            state_d  = ST_IDLE;
            dphase_d = 1'b1;
         end else begin
            state_d = ST_ACCESS;
            cnt_d   = 4'(WAIT_STATES);
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         dphase_q <= 1'b0;
         addr_q   <= 32'd0;
         write_q  <= 1'b0;
         size_q   <= 3'd0;
         hrdata_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dphase_q <= dphase_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         size_q   <= size_d;
         hrdata_q <= hrdata_d;
      end
   end

   always_ff @(posedge HCLK) begin
      if (complete && write_q) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_mask[i])
               mem[wr_idx][8*i +: 8] <= HWDATA[8*i +: 8];
         end
      end
   end

   assign unused_ok = ^{HBURST, HPROT, HTRANS[0], addr_q[31:AW+2]};

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- AHB-Lite responder: a word-organised on-chip SRAM with a configurable number of wait states and ERROR responses for illegal accesses.
- It is the subordinate end of the team's AHB-Lite bus. It receives the address/control/write-data signals driven by the master and returns HRDATA, HREADYOUT and HRESP.
- It is the target for master-side and bus-monitor verification.

Parameters:
- MEM_WORDS, 1024: depth of the 32-bit memory array. Byte address range is 0 .. MEM_WORDS*4-1.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted before completing every legal NONSEQ/SEQ data phase. Legal range 0..15.

Ports:
- HCLK in 1: bus clock; all state updates on the rising edge.
- HRESETn in 1: reset, asynchronous assert, active-low.
- HSEL in 1: slave select from the decoder.
- HADDR in 32: byte address.
- HTRANS in 2: IDLE/BUSY/NONSEQ/SEQ.
- HWRITE in 1: 1 = write.
- HSIZE in 3: 0 = byte, 1 = half, 2 = word; values above 2 are illegal.
- HBURST in 3: accepted and ignored; each beat is handled independently.
- HPROT in 4: accepted and ignored.
- HWDATA in 32: write data, valid in the data phase.
- HREADY in 1: bus-level ready. An address phase is only sampled when this is 1.
- HREADYOUT out 1: slave ready.
- HRESP out 1: 0 = OKAY, 1 = ERROR.
- HRDATA out 32: read data.

Behaviour:
- Reset (HRESETn=0, asynchronous): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, latched control cleared. Memory contents are not reset. Reset asserted mid-transfer abandons the transfer; a pending write is not committed.
- Address phase accept: HSEL & HREADY & HTRANS[1] at a rising edge. On accept, latch HADDR, HWRITE and HSIZE. Transfers with HTRANS = IDLE or BUSY are ignored and get a zero-wait OKAY (HREADYOUT=1, HRESP=0).
- Legality check, done at accept. A transfer is illegal if any of these hold:
  - HADDR >= MEM_WORDS*4
  - HSIZE > 2
  - HSIZE=1 with HADDR[0]=1
  - HSIZE=2 with HADDR[1:0]!=0
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0. Legal accept goes to ACCESS when WAIT_STATES>0, otherwise stays in a zero-wait data phase. Illegal accept goes to ERR1.
  - ACCESS: HREADYOUT=0, HRESP=0. The counter loads WAIT_STATES and decrements each cycle. At 0, HREADYOUT=1 for one cycle, the transfer completes, and the FSM returns to IDLE or accepts a new pipelined address in that same cycle.
  - ERR1: HREADYOUT=0, HRESP=1, for exactly one cycle, then go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1, for one cycle. No memory access. Then go to IDLE; a new accept may occur in this cycle.
- Pipelining: with WAIT_STATES=0, back-to-back NONSEQ/SEQ beats complete one per cycle.
- Writes: memory is updated at the rising edge ending the data phase (HREADYOUT=1, OKAY), using HWDATA.
  - Byte lanes are little-endian. Lane mask: byte = 1<<HADDR[1:0]; half = 3<<HADDR[1:0]; word = 4'hF.
  - Unselected bytes are unchanged.
- Reads: HRDATA = mem[addr_q[31:2]], full word, driven during the data phase. The value is valid in the cycle HREADYOUT=1, and HRDATA holds its value otherwise.
- Read-after-write: a read whose address phase coincides with the preceding write's completing data phase returns the newly written data.
- HWDATA is ignored on reads and on error transfers.

Decomposition:
- Package ahb_lite_pkg holds:
  - HTRANS constants: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - HSIZE constants: BYTE=0, HALF=1, WORD=2.
  - HRESP constants: OKAY=0, ERROR=1.
  - The slave FSM state enum.
- One sub-module, ahb_byte_lane_dec: (HSIZE, HADDR[1:0]) -> 4-bit lane mask. Purely combinational.

Test Plan:
- WAIT_STATES=0: write word 0xDEADBEEF @0x10, then read @0x10 -> HRDATA=0xDEADBEEF, HRESP=0, no HREADYOUT-low cycles.
- Byte write 0xAA @0x13 over 0x11223344 -> read @0x10 returns 0xAA223344. Half write 0x5566 @0x10 -> read returns 0xAA225566.
- WAIT_STATES=3: single read -> HREADYOUT low for exactly 3 cycles, data on the 4th. Back-to-back NONSEQ,SEQ,SEQ -> 12 data-phase cycles total.
- Read @MEM_WORDS*4 -> ERROR: cycle 1 (HREADYOUT=0, HRESP=1), cycle 2 (HREADYOUT=1, HRESP=1). Repeat for misaligned word @0x2 and for HSIZE=3; memory unchanged in all three cases.
- HSEL=1 with HTRANS=IDLE/BUSY, or HREADY=0 during an address phase -> no access, HREADYOUT=1, HRESP=0.
- Assert HRESETn=0 mid-ACCESS of a write -> outputs return to their reset values immediately, the target word is unchanged, and the next transfer after reset release completes normally.
